systolic_ctrl: RTL and testbench

Sequencer for an N×N array of `pe_generic` processing elements. It captures one A and one B operand matrix on a start handshake and clears the PE accumulators. It then drives the diagonally skewed row (A) and column (B) feeds cycle by cycle, waits for the pipeline to drain, and holds the array idle while it presents `done` until the consumer acknowledges. It sits between the operand source and the array's `in_a`/`in_b` edge ports.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/systolic_skew_gen.sv | 62 ++++++
 rtl/systolic_ctrl.sv | 117 +++++++++++
 tb/tb_systolic_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types for the systolic array sequencer.
// State encoding and feed schedule length.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } ctrl_state_t;

    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Operand capture and diagonally skewed row/column feed generation.
// Feeds are registered and load the value for index t on the edge entering t.
module systolic_skew_gen #(
    parameter int data_size = 4,
    parameter int N         = 4,
    parameter int TW        = $clog2(3 * N)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        en,
    input  logic [TW-1:0]               t,
    input  logic [N*N*data_size-1:0]    a_mat,
    input  logic [N*N*data_size-1:0]    b_mat,
    output logic [N*data_size-1:0]      a_feed,
    output logic [N*data_size-1:0]      b_feed
);

    localparam int W  = data_size;
    localparam int IW = $clog2(N);

    logic [W-1:0] a_q [N][N];
    logic [W-1:0] b_q [N][N];

    logic [N*W-1:0] a_n;
    logic [N*W-1:0] b_n;

    // Lane i lags t by i; negative lag wraps to a value >= N.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [TW-1:0] d;
        logic          hit;
        assign d   = t - TW'(i);
        assign hit = en && (d < TW'(N));
        assign a_n[i*W +: W] = hit ? a_q[i][d[IW-1:0]] : '0;
        assign b_n[i*W +: W] = hit ? b_q[d[IW-1:0]][i] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_feed <= '0;
            b_feed <= '0;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_q[i][k] <= '0;
                    b_q[i][k] <= '0;
                end
            end
        end else begin
            a_feed <= a_n;
            b_feed <= b_n;
            if (load) begin
                for (int i = 0; i < N; i++) begin
                    for (int k = 0; k < N; k++) begin
                        a_q[i][k] <= a_mat[(i*N+k)*W +: W];
                        b_q[i][k] <= b_mat[(i*N+k)*W +: W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN systolic array: capture, clear, skewed feed,
// drain, then hold results until acknowledged.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int data_size = 4,
    parameter int N         = 4,
    parameter int DRAIN_CYC = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        ready,
    input  logic [N*N*data_size-1:0]    a_mat,
    input  logic [N*N*data_size-1:0]    b_mat,
    output logic                        pe_clear,
    output logic [N*data_size-1:0]      a_feed,
    output logic [N*data_size-1:0]      b_feed,
    output logic                        feed_valid,
    output logic                        busy,
    output logic                        done,
    input  logic                        ack
);

    localparam int TW = $clog2(3 * N);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [TW-1:0] LAST  = TW'(feed_len(N) - 1);
    localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYC - 1);

    ctrl_state_t   state;
    logic [TW-1:0] t;
    logic [DW-1:0] dcnt;

    logic          load;
    logic          en;
    logic [TW-1:0] tsel;

    // ready follows reset directly so it drops the instant reset asserts.
    assign ready = reset && (state == IDLE);
    assign load  = ready && start;
    assign en    = (state == CLEAR) || ((state == FEED) && (t != LAST));
    assign tsel  = (state == FEED) ? t + TW'(1) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            t          <= '0;
            dcnt       <= '0;
            pe_clear   <= 1'b0;
            feed_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        pe_clear <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    state      <= FEED;
                    pe_clear   <= 1'b0;
                    feed_valid <= 1'b1;
                    t          <= '0;
                end
                FEED: begin
                    if (t == LAST) begin
                        state      <= DRAIN;
                        feed_valid <= 1'b0;
                        t          <= '0;
                        dcnt       <= '0;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                DRAIN: begin
                    if (dcnt == DLAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        dcnt  <= '0;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    systolic_skew_gen #(
        .data_size (data_size),
        .N         (N),
        .TW        (TW)
    ) u_skew (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .en     (en),
        .t      (tsel),
        .a_mat  (a_mat),
        .b_mat  (b_mat),
        .a_feed (a_feed),
        .b_feed (b_feed)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: N=2 and N=4 instances, the latter
// driving a behavioural 4x4 multiply-accumulate array.
module tb_systolic_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        s2 = 1'b0, k2 = 1'b0;
    logic        r2, c2, v2, bz2, d2;
    logic [15:0] am2 = '0, bm2 = '0;
    logic [7:0]  af2, bf2;

    logic        s4 = 1'b0, k4 = 1'b0;
    logic        r4, c4, v4, bz4, d4;
    logic [63:0] am4 = '0, bm4 = '0;
    logic [15:0] af4, bf4;

    int tests = 0;
    int fails = 0;

    int pa [4][4];
    int pb [4][4];
    int pc [4][4];

    systolic_ctrl #(.data_size(4), .N(2), .DRAIN_CYC(2)) u2 (
        .clk(clk), .reset(reset), .start(s2), .ready(r2),
        .a_mat(am2), .b_mat(bm2), .pe_clear(c2),
        .a_feed(af2), .b_feed(bf2), .feed_valid(v2),
        .busy(bz2), .done(d2), .ack(k2)
    );

    systolic_ctrl #(.data_size(4), .N(4), .DRAIN_CYC(2)) u4 (
        .clk(clk), .reset(reset), .start(s4), .ready(r4),
        .a_mat(am4), .b_mat(bm4), .pe_clear(c4),
        .a_feed(af4), .b_feed(bf4), .feed_valid(v4),
        .busy(bz4), .done(d4), .ack(k4)
    );

    function automatic int ain(int i, int j);
        if (j == 0) return int'($signed(af4[i*4 +: 4]));
        return pa[i][j-1];
    endfunction

    function automatic int bin(int i, int j);
        if (i == 0) return int'($signed(bf4[j*4 +: 4]));
        return pb[i-1][j];
    endfunction

    // Array of multiply-accumulate cells: a flows right, b flows down.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (c4) begin
                    pa[i][j] <= 0;
                    pb[i][j] <= 0;
                    pc[i][j] <= 0;
                end else begin
                    pa[i][j] <= ain(i, j);
                    pb[i][j] <= bin(i, j);
                    pc[i][j] <= pc[i][j] + ain(i, j) * bin(i, j);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if (r2 !== 1'b0) begin
            fails++; $display("FAIL reset_ready_low got %b want 0", r2);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (r2 !== 1'b1 || r4 !== 1'b1) begin
            fails++; $display("FAIL reset_ready got %b%b want 11", r2, r4);
        end
        tests++;
        if ({bz2, d2, c2, v2} !== 4'b0) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {bz2, d2, c2, v2});
        end
        tests++;
        if (af2 !== 8'h00 || bf2 !== 8'h00) begin
            fails++; $display("FAIL reset_feeds got %h/%h want 00/00", af2, bf2);
        end
        @(negedge clk);
    endtask

    task automatic test_skew();
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        ea = '{8'h01, 8'h32, 8'h40, 8'h00};
        eb = '{8'h05, 8'h67, 8'h80, 8'h00};
        am2 = 16'h4321;
        bm2 = 16'h8765;
        s2 = 1'b1;
        @(negedge clk);
        s2 = 1'b0;
        am2 = 16'hFFFF;
        bm2 = 16'hFFFF;
        tests++;
        if ({c2, bz2, r2} !== 3'b110) begin
            fails++; $display("FAIL skew_clear got %b want 110", {c2, bz2, r2});
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (af2 !== ea[c] || bf2 !== eb[c] || v2 !== 1'b1 || c2 !== 1'b0) begin
                fails++;
                $display("FAIL skew_t%0d got a=%h b=%h v=%b want a=%h b=%h v=1",
                         c, af2, bf2, v2, ea[c], eb[c]);
            end
        end
        for (int c = 6; c <= 8; c++) begin
            @(negedge clk);
            tests++;
            if (d2 !== (c == 8) || v2 !== 1'b0 || bz2 !== (c != 8)) begin
                fails++;
                $display("FAIL skew_done_k%0d got d=%b v=%b busy=%b want d=%b v=0",
                         c, d2, v2, bz2, c == 8);
            end
        end
        @(negedge clk);
        tests++;
        if (d2 !== 1'b1 || af2 !== 8'h00 || bf2 !== 8'h00) begin
            fails++; $display("FAIL skew_hold got d=%b a=%h b=%h want 1/00/00", d2, af2, bf2);
        end
        k2 = 1'b1;
        @(negedge clk);
        k2 = 1'b0;
        tests++;
        if (d2 !== 1'b0 || r2 !== 1'b1) begin
            fails++; $display("FAIL skew_ack got d=%b r=%b want 0/1", d2, r2);
        end
    endtask

    task automatic test_signed();
        int got;
        am2 = 16'h0008;
        bm2 = 16'h000F;
        s2 = 1'b1;
        @(negedge clk);
        s2 = 1'b0;
        @(negedge clk);
        tests++;
        if (af2 !== 8'h08 || bf2 !== 8'h0F) begin
            fails++; $display("FAIL signed_feed got a=%h b=%h want 08/0f", af2, bf2);
        end
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (d2) begin got = 1; break; end
        end
        tests++;
        if (got !== 1) begin
            fails++; $display("FAIL signed_done_timeout got %0d want 1", got);
        end
        k2 = 1'b1;
        @(negedge clk);
        k2 = 1'b0;
    endtask

    task automatic test_ack_start();
        int got;
        s2 = 1'b1;
        @(negedge clk);
        s2 = 1'b0;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (d2) begin got = 1; break; end
        end
        tests++;
        if (got !== 1) begin
            fails++; $display("FAIL ackstart_done_timeout got %0d want 1", got);
        end
        k2 = 1'b1;
        s2 = 1'b1;
        @(negedge clk);
        k2 = 1'b0;
        s2 = 1'b0;
        tests++;
        if (r2 !== 1'b1 || bz2 !== 1'b0 || d2 !== 1'b0) begin
            fails++; $display("FAIL ackstart_idle got r=%b busy=%b d=%b want 1/0/0", r2, bz2, d2);
        end
        @(negedge clk);
        tests++;
        if (bz2 !== 1'b0 || c2 !== 1'b0 || r2 !== 1'b1) begin
            fails++; $display("FAIL ackstart_norun got busy=%b clr=%b want 0/0", bz2, c2);
        end
    endtask

    task automatic test_full();
        int lat;
        int bad;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                am4[(i*4+k)*4 +: 4] = (i == k) ? 4'd1 : 4'd0;
                bm4[(i*4+k)*4 +: 4] = 4'(i + k);
            end
        end
        lat = 0;
        s4 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) s4 = 1'b0;
            if (d4) begin lat = n; break; end
        end
        tests++;
        if (lat !== 14) begin
            fails++; $display("FAIL full_latency got %0d want 14", lat);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (d4 !== 1'b1) begin
            fails++; $display("FAIL full_done_hold got %b want 1", d4);
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                tests++;
                if (pc[i][j] !== i + j) begin
                    fails++; $display("FAIL full_c%0d%0d got %0d want %0d", i, j, pc[i][j], i + j);
                end
            end
        end
        k4 = 1'b1;
        @(negedge clk);
        k4 = 1'b0;
        bad = pc[0][3];
        tests++;
        if (r4 !== 1'b1 || bad !== 3) begin
            fails++; $display("FAIL full_ack got r=%b c03=%0d want 1/3", r4, bad);
        end
    endtask

    task automatic test_start_busy();
        int lat;
        int hi;
        lat = 0;
        s4 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) s4 = 1'b0;
            if (n == 4) begin s4 = 1'b1; k4 = 1'b1; end
            if (n == 5) begin s4 = 1'b0; k4 = 1'b0; end
            if (d4) begin lat = n; break; end
        end
        tests++;
        if (lat !== 14) begin
            fails++; $display("FAIL busy_latency got %0d want 14", lat);
        end
        k4 = 1'b1;
        @(negedge clk);
        k4 = 1'b0;
        hi = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (bz4 || c4) hi++;
        end
        tests++;
        if (hi !== 0 || r4 !== 1'b1) begin
            fails++; $display("FAIL busy_norequeue got %0d busy cycles r=%b want 0/1", hi, r4);
        end
    endtask

    task automatic test_ack_first();
        int got;
        int cnt;
        got = 0;
        s4 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) s4 = 1'b0;
            if (d4) begin got = 1; break; end
        end
        k4 = 1'b1;
        cnt = got;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (d4) cnt++;
        end
        tests++;
        if (cnt !== 1 || r4 !== 1'b1) begin
            fails++; $display("FAIL ackfirst_done_cycles got %0d r=%b want 1/1", cnt, r4);
        end
        k4 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        s4 = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 1) s4 = 1'b0;
        end
        tests++;
        if (v4 !== 1'b1 || af4 !== 16'h0000 || bf4 !== 16'h5500) begin
            fails++; $display("FAIL mid_t5 got v=%b a=%h b=%h want 1/0000/5500", v4, af4, bf4);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({r4, bz4, v4, c4, d4} !== 5'b0) begin
            fails++; $display("FAIL mid_async_flags got %b want 00000", {r4, bz4, v4, c4, d4});
        end
        tests++;
        if (af4 !== 16'h0000 || bf4 !== 16'h0000) begin
            fails++; $display("FAIL mid_async_feeds got %h/%h want 0000/0000", af4, bf4);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        lat = 0;
        s4 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) s4 = 1'b0;
            if (d4) begin lat = n; break; end
        end
        tests++;
        if (lat !== 14) begin
            fails++; $display("FAIL mid_restart_latency got %0d want 14", lat);
        end
        tests++;
        if (pc[3][2] !== 5 || pc[1][1] !== 2) begin
            fails++; $display("FAIL mid_restart_result got %0d/%0d want 5/2", pc[3][2], pc[1][1]);
        end
        k4 = 1'b1;
        @(negedge clk);
        k4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_skew();
        test_signed();
        test_ack_start();
        test_full();
        test_start_busy();
        test_ack_first();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
